// File: rtl/ipm2l_hsstlp_apb_bridge_nch_if.sv
// Bus bundle for the HSST cfg APB bridge.
// Carries the fabric cfg port plus the shared downstream channel/PLL cfg bus.
interface ipm2l_hsstlp_apb_bridge_nch_if #(
  parameter int NUM_CH  = 4,
  parameter int NUM_PLL = 2
);
  logic                   p_cfg_psel;
  logic                   p_cfg_enable;
  logic                   p_cfg_write;
  logic [15:0]            p_cfg_addr;
  logic [7:0]             p_cfg_wdata;
  logic                   p_cfg_ready;
  logic [7:0]             p_cfg_rdata;
  logic                   p_cfg_slverr;
  logic                   p_cfg_int;

  logic [NUM_CH-1:0]      ch_psel;
  logic [NUM_PLL-1:0]     pll_psel;
  logic                   s_enable;
  logic                   s_write;
  logic [11:0]            s_addr;
  logic [7:0]             s_wdata;
  logic [NUM_CH-1:0]      ch_ready;
  logic [8*NUM_CH-1:0]    ch_rdata;
  logic [NUM_CH-1:0]      ch_int;
  logic [NUM_PLL-1:0]     pll_ready;
  logic [8*NUM_PLL-1:0]   pll_rdata;
  logic [NUM_PLL-1:0]     pll_int;

  // Bridge view: slave on the fabric cfg port, master on the downstream bus.
  modport slave (
    input  p_cfg_psel, p_cfg_enable, p_cfg_write, p_cfg_addr, p_cfg_wdata,
    input  ch_ready, ch_rdata, ch_int, pll_ready, pll_rdata, pll_int,
    output p_cfg_ready, p_cfg_rdata, p_cfg_slverr, p_cfg_int,
    output ch_psel, pll_psel, s_enable, s_write, s_addr, s_wdata
  );

  modport master (
    output p_cfg_psel, p_cfg_enable, p_cfg_write, p_cfg_addr, p_cfg_wdata,
    output ch_ready, ch_rdata, ch_int, pll_ready, pll_rdata, pll_int,
    input  p_cfg_ready, p_cfg_rdata, p_cfg_slverr, p_cfg_int,
    input  ch_psel, pll_psel, s_enable, s_write, s_addr, s_wdata
  );
endinterface

// File: rtl/ipm2l_hsstlp_apb_bridge_nch.sv
// Registered APB bridge from the fabric cfg port to HSST channel and PLL cfg slaves,
// with access timeout, error responses and masked interrupt aggregation.
module ipm2l_hsstlp_apb_bridge_nch #(
  parameter int         NUM_CH  = 4,
  parameter int         NUM_PLL = 2,
  parameter logic [3:0] CH_EN   = 4'b1111,
  parameter logic [1:0] PLL_EN  = 2'b11,
  parameter int         TIMEOUT = 255
) (
  input  logic                        p_cfg_clk,
  input  logic                        p_cfg_rst,
  ipm2l_hsstlp_apb_bridge_nch_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;

  localparam logic [11:0] ADDR_INT_MASK = 12'h000;
  localparam logic [11:0] ADDR_IRQ_RAW  = 12'h001;
  localparam logic [11:0] ADDR_ERR_STAT = 12'h002;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_idx;
  logic                 r_write;
  logic [11:0]          r_addr;
  logic [7:0]           r_wdata;
  logic [7:0]           r_rdata;
  logic                 r_slverr;
  logic                 r_int;
  logic [7:0]           r_int_mask;
  logic [1:0]           r_err_stat;
  logic [7:0]           r_cnt;

  logic [3:0]           w_in_idx;
  logic                 w_start;
  logic                 w_local;
  logic                 w_hit;
  logic                 w_busy;
  logic                 w_sel_ready;
  logic [7:0]           w_sel_rdata;
  logic                 w_timeout;
  logic [7:0]           w_irq;
  logic [7:0]           w_local_rdata;
  logic [1:0]           w_err_set;
  logic [1:0]           w_err_clr;
  logic [NUM_CH-1:0]    w_ch_psel;
  logic [NUM_PLL-1:0]   w_pll_psel;

  assign w_in_idx = bus.p_cfg_addr[15:12];
  assign w_start  = (r_state == ST_IDLE) && bus.p_cfg_psel && bus.p_cfg_enable;
  assign w_local  = (w_in_idx == 4'hF);
  assign w_busy   = (r_state == ST_SETUP) || (r_state == ST_ACCESS);

  always_comb begin
    w_hit = 1'b0;
    for (int k = 0; k < NUM_CH; k++)
      if (w_in_idx == 4'(k) && CH_EN[k]) w_hit = 1'b1;
    for (int j = 0; j < NUM_PLL; j++)
      if (w_in_idx == 4'(4 + j) && PLL_EN[j]) w_hit = 1'b1;
  end

  always_comb begin
    w_irq = '0;
    for (int k = 0; k < NUM_CH; k++) w_irq[k] = bus.ch_int[k];
    for (int j = 0; j < NUM_PLL; j++) w_irq[4 + j] = bus.pll_int[j];
    w_irq[6] = |r_err_stat;
  end

  always_comb begin
    w_local_rdata = 8'h00;
    case (bus.p_cfg_addr[11:0])
      ADDR_INT_MASK: w_local_rdata = r_int_mask;
      ADDR_IRQ_RAW:  w_local_rdata = w_irq;
      ADDR_ERR_STAT: w_local_rdata = {6'b000000, r_err_stat};
      default:       w_local_rdata = 8'h00;
    endcase
  end

  // Ready/rdata of the slave latched at the start of the transfer.
  always_comb begin
    w_sel_ready = 1'b0;
    w_sel_rdata = 8'h00;
    for (int k = 0; k < NUM_CH; k++)
      if (r_idx == 4'(k)) begin
        w_sel_ready = bus.ch_ready[k];
        w_sel_rdata = bus.ch_rdata[8*k +: 8];
      end
    for (int j = 0; j < NUM_PLL; j++)
      if (r_idx == 4'(4 + j)) begin
        w_sel_ready = bus.pll_ready[j];
        w_sel_rdata = bus.pll_rdata[8*j +: 8];
      end
  end

  // r_cnt holds completed ACCESS cycles, so +1 counts the current one.
  assign w_timeout = (TIMEOUT != 0) && (({1'b0, r_cnt} + 9'd1) == 9'(TIMEOUT));

  assign w_err_clr = (w_start && w_local && bus.p_cfg_write &&
                      bus.p_cfg_addr[11:0] == ADDR_ERR_STAT) ? bus.p_cfg_wdata[1:0] : 2'b00;

  always_ff @(posedge p_cfg_clk or posedge p_cfg_rst) begin
    if (p_cfg_rst) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_set   = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          if (w_local) begin
            w_state_nxt = ST_RESP;
          end else if (w_hit) begin
            w_state_nxt = ST_SETUP;
          end else begin
            w_state_nxt  = ST_RESP;
            w_err_set[1] = 1'b1;
          end
        end
      end
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (w_sel_ready) begin
          w_state_nxt = ST_RESP;
        end else if (w_timeout) begin
          w_state_nxt  = ST_RESP;
          w_err_set[0] = 1'b1;
        end
      end
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge p_cfg_clk or posedge p_cfg_rst) begin
    if (p_cfg_rst) begin
      r_idx      <= 4'h0;
      r_write    <= 1'b0;
      r_addr     <= 12'h000;
      r_wdata    <= 8'h00;
      r_rdata    <= 8'h00;
      r_slverr   <= 1'b0;
      r_int      <= 1'b0;
      r_int_mask <= 8'h00;
      r_err_stat <= 2'b00;
      r_cnt      <= 8'h00;
    end else begin
      if (w_start) begin
        r_idx   <= w_in_idx;
        r_write <= bus.p_cfg_write;
        r_addr  <= bus.p_cfg_addr[11:0];
        r_wdata <= bus.p_cfg_wdata;
        if (w_local) begin
          r_slverr <= 1'b0;
          r_rdata  <= bus.p_cfg_write ? 8'h00 : w_local_rdata;
          if (bus.p_cfg_write && bus.p_cfg_addr[11:0] == ADDR_INT_MASK)
            r_int_mask <= bus.p_cfg_wdata;
        end else if (!w_hit) begin
          r_slverr <= 1'b1;
          r_rdata  <= 8'h00;
        end
      end
      if (r_state == ST_SETUP) r_cnt <= 8'h00;
      if (r_state == ST_ACCESS) begin
        r_cnt <= r_cnt + 8'd1;
        if (w_sel_ready) begin
          r_rdata  <= w_sel_rdata;
          r_slverr <= 1'b0;
        end else if (w_timeout) begin
          r_rdata  <= 8'h00;
          r_slverr <= 1'b1;
        end
      end
      r_err_stat <= (r_err_stat & ~w_err_clr) | w_err_set;
      r_int      <= |(w_irq & r_int_mask);
    end
  end

  always_comb begin
    w_ch_psel  = '0;
    w_pll_psel = '0;
    for (int k = 0; k < NUM_CH; k++)  w_ch_psel[k]  = w_busy && (r_idx == 4'(k));
    for (int j = 0; j < NUM_PLL; j++) w_pll_psel[j] = w_busy && (r_idx == 4'(4 + j));
  end

  assign bus.ch_psel      = w_ch_psel;
  assign bus.pll_psel     = w_pll_psel;
  assign bus.s_enable     = (r_state == ST_ACCESS);
  assign bus.s_write      = r_write;
  assign bus.s_addr       = r_addr;
  assign bus.s_wdata      = r_wdata;
  assign bus.p_cfg_ready  = (r_state == ST_RESP);
  assign bus.p_cfg_rdata  = r_rdata;
  assign bus.p_cfg_slverr = r_slverr;
  assign bus.p_cfg_int    = r_int;

endmodule

// File: doc/ipm2l_hsstlp_apb_bridge_nch.md
Name: ipm2l_hsstlp_apb_bridge_nch

Overview:
- Registered APB bridge from the fabric cfg port to NUM_CH HSST channel and NUM_PLL PLL cfg slaves.
- Decode on p_cfg_addr[15:12]: channel k at index k, PLL j at index 4+j, local registers at index 4'hF.
- Timeout on every downstream access; error response for disabled/unmapped slaves.
- Masked, registered interrupt aggregation with local mask/status registers.

Parameters:
- NUM_CH, 4, channel slaves, 1..4
- NUM_PLL, 2, PLL slaves, 1..2
- CH_EN, 4'b1111, per-channel enable bitmask; bit k=0 makes channel k unmapped
- PLL_EN, 2'b11, per-PLL enable bitmask
- TIMEOUT, 255, max ACCESS cycles waiting for slave ready, 1..255; 0 disables timeout

Ports:
- p_cfg_clk  in  1  cfg clock
- p_cfg_rst  in  1  asynchronous reset, active-high
- p_cfg_psel  in  1  upstream APB select
- p_cfg_enable  in  1  upstream APB enable
- p_cfg_write  in  1  upstream write
- p_cfg_addr  in  16  [15:12] slave index, [11:0] slave address
- p_cfg_wdata  in  8  write data
- p_cfg_ready  out  1  one-cycle completion pulse
- p_cfg_rdata  out  8  read data, valid with p_cfg_ready
- p_cfg_slverr  out  1  error flag, valid with p_cfg_ready
- p_cfg_int  out  1  masked interrupt
- ch_psel  out  NUM_CH  per-channel select
- pll_psel  out  NUM_PLL  per-PLL select
- s_enable  out  1  shared downstream enable
- s_write  out  1  shared downstream write
- s_addr  out  12  shared downstream address, registered
- s_wdata  out  8  shared downstream write data, registered
- ch_ready  in  NUM_CH  channel ready
- ch_rdata  in  8*NUM_CH  channel read data; channel k at [8k+7:8k]
- ch_int  in  NUM_CH  channel interrupts
- pll_ready  in  NUM_PLL  PLL ready
- pll_rdata  in  8*NUM_PLL  PLL read data
- pll_int  in  NUM_PLL  PLL interrupts

Behaviour:
- Reset, asynchronous:
  - FSM to IDLE.
  - All psel, s_enable, s_write, p_cfg_ready, p_cfg_slverr, p_cfg_int = 0.
  - s_addr, s_wdata, p_cfg_rdata = 0.
  - INT_MASK = 0x00; ERR_STAT = 0x00.
  - Reset mid-transfer aborts it with no response; downstream selects drop immediately.
- Interrupt vector IRQ[7:0]:
  - bits 0..3 = ch_int (unused bits 0).
  - bits 4..5 = pll_int (unused bits 0).
  - bit 6 = |ERR_STAT.
  - bit 7 = 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Waits for p_cfg_psel & p_cfg_enable.
  - Latches write, addr[11:0] and wdata into s_write/s_addr/s_wdata, plus the slave index.
  - Enabled slave -> SETUP.
  - Index 4'hF -> local register access -> RESP, slverr=0.
  - Any other index, including disabled or beyond NUM_CH/NUM_PLL -> RESP with slverr=1, rdata=0; sets ERR_STAT[1].
- SETUP: selected psel=1, s_enable=0, for one cycle -> ACCESS.
- ACCESS:
  - Selected psel=1, s_enable=1; a counter increments each cycle.
  - Selected ready=1 -> register that slave's rdata -> RESP, slverr=0.
  - Otherwise, if TIMEOUT!=0 and count==TIMEOUT -> RESP, slverr=1, rdata=0; sets ERR_STAT[0].
  - Ready and timeout in the same cycle: ready wins.
- RESP:
  - Downstream psel/s_enable = 0.
  - p_cfg_ready=1 for exactly one cycle with rdata/slverr.
  - Next state IDLE.
  - p_cfg_ready is 0 in all other states.
- Latency, cycles from the IDLE cycle that samples the access to the p_cfg_ready pulse:
  - 3 with a zero-wait slave (+1 per slave wait cycle).
  - 1 for local or unmapped accesses.
- Upstream inputs are ignored outside IDLE. The upstream master must hold its access until ready, per APB.
- Local registers:
  - 0xF000 INT_MASK: RW.
  - 0xF001 IRQ_RAW: RO = IRQ; writes ignored.
  - 0xF002 ERR_STAT: bit0 timeout, bit1 unmapped; sticky, write-1-to-clear. Hardware set wins over a same-cycle clear.
  - Other 0xFxxx addresses read 0; writes ignored; slverr=0.
- p_cfg_int is registered: p_cfg_int <= |(IRQ & INT_MASK), one cycle after any change.

Test Plan:
- Write 0x5A to 0x2010, ch_ready tied 1:
  - ch_psel=4'b0100 and s_addr=0x010, s_wdata=0x5A for 2 cycles; s_enable high only in the second.
  - p_cfg_ready pulses 3 cycles after the access is sampled, slverr=0.
- Read 0x4003, pll_rdata[7:0]=0xC3, pll_ready low for 4 ACCESS cycles then high:
  - p_cfg_rdata=0xC3 with a single ready pulse, slverr=0.
- Read channel 1 with ch_ready stuck 0, TIMEOUT=8:
  - psel drops after 8 ACCESS cycles; ready pulse with slverr=1, rdata=0x00; ERR_STAT reads 0x01.
  - Write 0x01 to 0xF002 -> ERR_STAT reads 0x00.
- CH_EN=4'b1101, read 0x1000 (disabled channel 1), then read 0x7000 (no slave):
  - Each returns a ready pulse 1 cycle after sampling, slverr=1, rdata=0, no psel asserted; ERR_STAT=0x02.
- Write INT_MASK=0x10, then pulse pll_int[0] high:
  - p_cfg_int rises one cycle later; raising ch_int[0] alone leaves p_cfg_int=0.
  - IRQ_RAW read at 0xF001 returns 0x11 while both interrupts are held high.
- Assert p_cfg_rst during ACCESS:
  - All psel/s_enable = 0 immediately, with no ready pulse.
  - After release, a fresh transfer completes normally and INT_MASK reads 0x00.
